// File: rtl/fetch_queue_pkg.sv
// Shared widths, defaults and types for the instruction prefetch queue.
// Imported by the ring buffer and the fetch_queue top level.
package fetch_queue_pkg;

    localparam int unsigned PC_W          = 16;
    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular buffer of {pc, instr} entries with head/tail pointers and occupancy.
// The head entry is kept in a register so it holds its last value when empty.
module fq_ring
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fq_entry_t        wdata,
    output fq_entry_t        rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fq_entry_t        rdata_q, rdata_d;
    fq_entry_t        mem [DEPTH];
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) head_d = head_q + 1'b1;
            if (push)   tail_d = tail_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
            // When the pushed entry lands in the new head slot, bypass the array.
            if (count_d != '0) begin
                rdata_d = (push && ((count_q - CNT_W'(do_pop)) == '0)) ? wdata : mem[head_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail_q] <= wdata;
    end

    assign rdata = rdata_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: issues sequential IM reads, buffers responses with
// their PCs, and hands them to decode over valid/ready; redirect flushes and restarts.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned      DEPTH    = DEFAULT_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned      CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               im_rd_en,
    output logic [PC_W-1:0]    im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   count
);

    fq_state_e       state_q;
    logic [PC_W-1:0] fetch_pc_q, pend_pc_q;
    logic            inflight_q, drop_q;
    logic            issue, push, pop;
    fq_entry_t       wdata, rdata;

    // Credit check counts the in-flight read so a response always has a slot.
    assign issue = (state_q == StRun) && !redirect_valid
                   && ((32'(count) + 32'(inflight_q)) < DEPTH);
    assign push  = inflight_q && !drop_q && !redirect_valid;
    assign pop   = out_valid && out_ready && !redirect_valid;

    assign wdata = '{pc: pend_pc_q, instr: im_instr};

    fq_ring #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect_valid) begin
                state_q    <= StFlush;
                fetch_pc_q <= redirect_pc;
                drop_q     <= inflight_q;
            end else begin
                drop_q <= 1'b0;
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + 1'b1;
                    pend_pc_q  <= fetch_pc_q;
                end
                unique case (state_q)
                    StBoot:  state_q <= StRun;
                    StRun:   state_q <= StRun;
                    StFlush: state_q <= StRun;
                    default: state_q <= StBoot;
                endcase
            end
        end
    end

    assign im_rd_en  = issue;
    assign im_addr   = fetch_pc_q;
    assign out_valid = (count != '0);
    assign out_instr = rdata.instr;
    assign out_pc    = rdata.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential streaming, back-pressure, redirects,
// PC wrap and asynchronous reset, against hand-computed PCs and a simple IM model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_instr = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000),
        .CNT_W    (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_rd_en       (im_rd_en),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] instr_of(input logic [15:0] pc);
        return pc ^ 16'hA5A5;
    endfunction

    // IM returns data the cycle after the read request.
    always @(posedge clk) begin
        if (im_rd_en) im_instr <= instr_of(im_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) check("count_le_depth", {31'b0, count <= 3'd4}, 32'd1);
    end

    initial begin
        int issues;
        int first_step;
        logic [15:0] first_pc;
        logic seen_10;

        // Reset values
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_im_rd_en", im_rd_en, 0);
        check("rst_im_addr", im_addr, 16'h0000);
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b1;

        // Free-running stream from RESET_PC
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("stream_rd_en", im_rd_en, 1);
            check("stream_addr", im_addr, 32'(k - 1));
            if (k < 3) begin
                check("stream_early_valid", out_valid, 0);
            end else begin
                check("stream_valid", out_valid, 1);
                check("stream_pc", out_pc, 32'(k - 3));
                check("stream_instr", out_instr, instr_of(16'(k - 3)));
            end
        end

        // Back-pressure: fill to DEPTH, then a single pop
        out_ready = 1'b0;
        do_reset();
        issues = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (im_rd_en) issues++;
        end
        check("bp_issues", issues, 4);
        check("bp_rd_en", im_rd_en, 0);
        check("bp_count", count, 4);
        check("bp_pc_held", out_pc, 16'h0000);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pulse_pc", out_pc, 16'h0001);
        check("pulse_instr", out_instr, instr_of(16'h0001));
        check("pulse_count", count, 3);
        check("pulse_addr", im_addr, 16'h0004);
        issues = im_rd_en ? 1 : 0;
        step();
        if (im_rd_en) issues++;
        step();
        if (im_rd_en) issues++;
        check("pulse_issues", issues, 1);
        check("pulse_refill", count, 4);

        // Redirect with 3 queued entries and one read in flight
        do_reset();
        for (int k = 1; k <= 5; k++) step();
        check("pre_redir_count", count, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("redir_count", count, 0);
        check("redir_valid", out_valid, 0);
        step();
        check("redir_issue", im_rd_en, 1);
        check("redir_addr", im_addr, 16'h0040);
        check("redir_valid1", out_valid, 0);
        step();
        check("redir_valid2", out_valid, 0);
        step();
        check("redir_first_valid", out_valid, 1);
        check("redir_first_pc", out_pc, 16'h0040);
        check("redir_first_instr", out_instr, instr_of(16'h0040));

        // Back-to-back redirects: last target wins
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        step();
        redirect_pc    = 16'h0020;
        step();
        redirect_valid = 1'b0;
        first_step = 0;
        first_pc   = 16'h0000;
        seen_10    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (out_valid && out_pc == 16'h0010) seen_10 = 1'b1;
            if (out_valid && first_step == 0) begin
                first_step = k;
                first_pc   = out_pc;
            end
        end
        check("dbl_first_pc", first_pc, 16'h0020);
        check("dbl_latency", first_step, 3);
        check("dbl_no_0010", seen_10, 0);

        // PC wrap at 16'hFFFF
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        check("wrap_pc0", out_pc, 16'hFFFE);
        step();
        check("wrap_pc1", out_pc, 16'hFFFF);
        step();
        check("wrap_pc2", out_pc, 16'h0000);
        check("wrap_instr2", out_instr, instr_of(16'h0000));
        step();
        check("wrap_pc3", out_pc, 16'h0001);
        check("wrap_valid3", out_valid, 1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 4; k++) step();
        check("arst_pre_count", count, 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", count, 0);
        check("arst_rd_en", im_rd_en, 0);
        check("arst_addr", im_addr, 16'h0000);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_resume_addr", im_addr, 16'h0000);
        check("arst_resume_rd", im_rd_en, 1);
        step();
        step();
        check("arst_resume_valid", out_valid, 1);
        check("arst_resume_pc", out_pc, 16'h0000);
        step();
        check("arst_resume_pc1", out_pc, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
